// File: rtl/lfsr_chk.sv
// Receive-side checker for a Galois LFSR word stream: self-seeds, verifies successive
// words, declares lock after a run of matches and counts mismatches while locked.
module lfsr_chk #(
  parameter int                 WIDTH    = 20,
  parameter logic [WIDTH-1:0]   TAPS     = 20'b10001001000010110000,
  parameter int                 LOCK_CNT = 4,
  parameter int                 LOSS_CNT = 3,
  parameter int                 ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_CNT);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC,
    ST_LOCKED
  } state_e;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {1'b0, v[WIDTH-1:1]} ^ (v[0] ? TAPS : '0);
  endfunction

  // Saturating increment: the counter parks at all ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    exp_q, exp_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

  logic                match;
  logic                data_zero;
  logic [RUN_W-1:0]    run_inc;
  logic [MISS_W-1:0]   miss_inc;

  assign match     = (in_data == exp_q);
  assign data_zero = (in_data == '0);
  assign run_inc   = run_q + RUN_W'(1);
  assign miss_inc  = miss_q + MISS_W'(1);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (!data_zero) begin
            exp_d   = lfsr_step(in_data);
            run_d   = '0;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (match) begin
            exp_d = lfsr_step(exp_q);
            run_d = run_inc;
            if (run_inc == RUN_LOCK) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else if (!data_zero) begin
            exp_d = lfsr_step(in_data);
            run_d = '0;
          end else begin
            state_d = ST_HUNT;
            run_d   = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: once locked the prediction never reseeds from received data.
          exp_d = lfsr_step(exp_q);
          if (match) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc(err_cnt_q);
            if (miss_inc == MISS_LOSS) begin
              state_d  = ST_HUNT;
              locked_d = 1'b0;
              miss_d   = '0;
              run_d    = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d  = ST_HUNT;
          locked_d = 1'b0;
        end
      endcase
    end

    // A clear always beats a coincident increment; the pulse is unaffected.
    if (clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  // Stage boundary: all checker state and outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      exp_q       <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lfsr_chk.sv
// Bench for lfsr_chk: directed scenarios plus a randomized stream, two builds side by side
// (default, and a 2-bit counter with a long loss threshold) against a behavioural model.
module tb_lfsr_chk;

  localparam logic [19:0] TAPS = 20'h890B0;

  logic        clk = 1'b0;
  logic        rst, in_valid, clr_cnt;
  logic [19:0] in_data;
  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  lfsr_chk #(.WIDTH(20), .TAPS(TAPS), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked_a), .err_pulse(pulse_a), .err_cnt(cnt_a));

  lfsr_chk #(.WIDTH(20), .TAPS(TAPS), .LOCK_CNT(4), .LOSS_CNT(7), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked_b), .err_pulse(pulse_b), .err_cnt(cnt_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: mode 0 hunting, 1 verifying, 2 locked; index 0 = dut_a, 1 = dut_b.
  int          m_mode[2];
  logic [19:0] m_pred[2];
  int          m_run[2], m_miss[2], m_err[2];
  bit          m_lk[2], m_pl[2];
  int          loss_n[2] = '{3, 7};
  int          err_max[2] = '{65535, 3};

  function automatic logic [19:0] nxt(input logic [19:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 20'h0);
  endfunction

  task automatic model_step(input int k);
    bit bad;
    bad = 1'b0;
    if (rst) begin
      m_mode[k] = 0; m_pred[k] = 0; m_run[k] = 0; m_miss[k] = 0;
      m_err[k] = 0; m_lk[k] = 0; m_pl[k] = 0;
      return;
    end
    m_pl[k] = 0;
    if (in_valid) begin
      if (m_mode[k] == 0) begin
        if (in_data != 0) begin
          m_pred[k] = nxt(in_data); m_run[k] = 0; m_mode[k] = 1;
        end
      end else if (m_mode[k] == 1) begin
        if (in_data == m_pred[k]) begin
          m_pred[k] = nxt(m_pred[k]);
          m_run[k]++;
          if (m_run[k] == 4) begin m_mode[k] = 2; m_lk[k] = 1; end
        end else if (in_data != 0) begin
          m_pred[k] = nxt(in_data); m_run[k] = 0;
        end else begin
          m_mode[k] = 0; m_run[k] = 0;
        end
      end else begin
        bad = (in_data != m_pred[k]);
        m_pred[k] = nxt(m_pred[k]);
        if (!bad) m_miss[k] = 0;
        else begin
          m_pl[k] = 1;
          m_miss[k]++;
          if (m_miss[k] == loss_n[k]) begin
            m_mode[k] = 0; m_lk[k] = 0; m_miss[k] = 0; m_run[k] = 0;
          end
        end
      end
    end
    if (clr_cnt) m_err[k] = 0;
    else if (bad && m_err[k] < err_max[k]) m_err[k]++;
  endtask

  task automatic cyc(input bit v, input logic [19:0] d, input bit c = 1'b0, input bit r = 1'b0);
    @(negedge clk);
    in_valid = v; in_data = d; clr_cnt = c; rst = r;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("locked_a", 32'(locked_a), 32'(m_lk[0]));
    check("pulse_a",  32'(pulse_a),  32'(m_pl[0]));
    check("cnt_a",    32'(cnt_a),    32'(m_err[0]));
    check("locked_b", 32'(locked_b), 32'(m_lk[1]));
    check("pulse_b",  32'(pulse_b),  32'(m_pl[1]));
    check("cnt_b",    32'(cnt_b),    32'(m_err[1]));
  endtask

  task automatic lock_from(input logic [19:0] seed, output logic [19:0] nxt_word);
    logic [19:0] w;
    w = seed;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, w);
      w = nxt(w);
    end
    nxt_word = w;
  endtask

  logic [19:0] g;
  int          pulses_b;
  int          r;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_cnt = 1'b0;
    cyc(1'b0, 20'h0, 1'b0, 1'b1);
    cyc(1'b0, 20'h0, 1'b0, 1'b1);
    check("rst_locked", 32'(locked_a), 32'd0);
    check("rst_pulse",  32'(pulse_a),  32'd0);
    check("rst_cnt",    32'(cnt_a),    32'd0);

    // Zero words never seed.
    repeat (5) cyc(1'b1, 20'h0);
    check("zero_hunt_locked", 32'(locked_a), 32'd0);

    // Known stream locks after the fourth verified word.
    cyc(1'b1, 20'h00001); cyc(1'b1, 20'h890B0); cyc(1'b1, 20'h44858); cyc(1'b1, 20'h2242C);
    check("pre_lock", 32'(locked_a), 32'd0);
    cyc(1'b1, 20'h11216);
    check("lock_seq", 32'(locked_a), 32'd1);
    check("lock_cnt0", 32'(cnt_a), 32'd0);

    // Same stream with gaps.
    cyc(1'b0, 20'h0, 1'b0, 1'b1);
    cyc(1'b1, 20'h00001); cyc(1'b0, 20'h0); cyc(1'b1, 20'h890B0); cyc(1'b0, 20'h0);
    cyc(1'b0, 20'h0);     cyc(1'b1, 20'h44858); cyc(1'b1, 20'h2242C); cyc(1'b0, 20'h0);
    cyc(1'b1, 20'h11216);
    check("lock_gaps", 32'(locked_a), 32'd1);

    // Single bad word, then flywheel match.
    cyc(1'b1, 20'h0890A);
    check("bad_pulse", 32'(pulse_a), 32'd1);
    check("bad_cnt",   32'(cnt_a),   32'd1);
    check("bad_lock",  32'(locked_a), 32'd1);
    cyc(1'b1, 20'h8D435);
    check("fly_pulse", 32'(pulse_a), 32'd0);
    check("fly_lock",  32'(locked_a), 32'd1);

    // Three consecutive bad words drop lock, then relock on a new stream.
    g = nxt(20'h8D435);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, g ^ 20'h00400);
      g = nxt(g);
    end
    check("loss_lock", 32'(locked_a), 32'd0);
    check("loss_cnt",  32'(cnt_a),    32'd4);
    lock_from(20'h5A5A5, g);
    check("relock", 32'(locked_a), 32'd1);

    // Saturation on the narrow build, clear coincident with a mismatch.
    cyc(1'b0, 20'h0, 1'b0, 1'b1);
    lock_from(20'h00777, g);
    pulses_b = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, ~g);
      if (pulse_b) pulses_b++;
      g = nxt(g);
    end
    check("sat_cnt_b", 32'(cnt_b), 32'd3);
    check("sat_pulses_b", 32'(pulses_b), 32'd5);
    cyc(1'b1, ~g, 1'b1);
    g = nxt(g);
    check("clr_cnt_b",   32'(cnt_b),   32'd0);
    check("clr_pulse_b", 32'(pulse_b), 32'd1);

    // Reseed during verification, then reset while locked.
    cyc(1'b0, 20'h0, 1'b0, 1'b1);
    cyc(1'b1, 20'h00001); cyc(1'b1, 20'h890B0); cyc(1'b1, 20'h44858);
    cyc(1'b1, 20'h12345);
    g = nxt(20'h12345);
    for (int i = 0; i < 3; i++) begin cyc(1'b1, g); g = nxt(g); end
    check("reseed_wait", 32'(locked_a), 32'd0);
    cyc(1'b1, g); g = nxt(g);
    check("reseed_lock", 32'(locked_a), 32'd1);
    cyc(1'b1, ~g);
    cyc(1'b1, 20'h0, 1'b0, 1'b1);
    check("rst_mid_locked", 32'(locked_a), 32'd0);
    check("rst_mid_pulse",  32'(pulse_a),  32'd0);
    check("rst_mid_cnt",    32'(cnt_a),    32'd0);

    // Randomized stream with gaps, corruptions, zeros, restarts, clears and resets.
    g = 20'(($urandom % 20'hFFFFE) + 1);
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 150)      cyc(1'b0, 20'($urandom), r < 10);
      else if (r < 800) begin cyc(1'b1, g, r > 790); g = nxt(g); end
      else if (r < 920) begin cyc(1'b1, g ^ 20'(1 << $urandom_range(0, 19))); g = nxt(g); end
      else if (r < 950) begin cyc(1'b1, 20'h0); g = nxt(g); end
      else if (r < 997) g = 20'(($urandom % 20'hFFFFE) + 1);
      else              cyc(1'b1, g, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
